// File: rtl/lock_pkg.sv
// Shared types and helpers for the serial-entry code lock.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        OPEN,
        LOCKOUT,
        FIRE
    } lock_state_t;

    localparam int unsigned MAX_CODE_W  = 256;
    localparam int unsigned MAX_DIGIT_W = 32;

    // Digit 0 sits in the MSBs of the code vector.
    function automatic logic [MAX_DIGIT_W-1:0] code_digit(
        input logic [MAX_CODE_W-1:0] code,
        input int unsigned           idx,
        input int unsigned           n_digits,
        input int unsigned           digit_w
    );
        logic [MAX_CODE_W-1:0]  shifted;
        logic [MAX_DIGIT_W-1:0] mask;
        shifted = code >> ((n_digits - 1 - idx) * digit_w);
        mask    = (digit_w >= MAX_DIGIT_W) ? '1 : MAX_DIGIT_W'((64'd1 << digit_w) - 64'd1);
        return shifted[MAX_DIGIT_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Shared up-counter for the OPEN hold time and the inter-digit timeout.
module lock_timer #(
    parameter int unsigned TMR_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [TMR_W-1:0] limit,
    output logic [TMR_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/seq_code_lock.sv
// Serial-entry code lock with fail lockout, master-code recovery and fire override.
//
//   state   | meaning
//   IDLE    | waiting for the first digit of a user attempt
//   ENTRY   | user attempt in progress, inter-digit timeout armed
//   OPEN    | door released for OPEN_CYCLES or until relock
//   LOCKOUT | siren on, entry checked against the master code
//   FIRE    | fire override, door held open, digits ignored
module seq_code_lock
    import lock_pkg::*;
#(
    parameter int unsigned N_DIGITS       = 5,
    parameter int unsigned DIGIT_W        = 4,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned OPEN_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned CNT_W   = $clog2(MAX_FAIL + 1),
    localparam int unsigned POS_W   = $clog2(N_DIGITS + 1),
    localparam int unsigned TMR_MAX = (OPEN_CYCLES > TIMEOUT_CYCLES) ? OPEN_CYCLES : TIMEOUT_CYCLES,
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1),
    localparam int unsigned CODE_W  = N_DIGITS * DIGIT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic              digit_valid,
    input  logic [CODE_W-1:0] user_code,
    input  logic [CODE_W-1:0] master_code,
    input  logic              fire_alarm,
    input  logic              relock,
    output logic              unlock,
    output logic              alarm,
    output logic [CNT_W-1:0]  fail_count,
    output logic [POS_W-1:0]  digit_pos
);

    lock_state_t        state;
    logic               mismatch;
    logic               mismatch_next;
    logic               last_digit;
    logic               entry_active;
    logic [CODE_W-1:0]  ref_code;
    logic [DIGIT_W-1:0] ref_digit;
    logic [CNT_W-1:0]   fail_inc;
    logic               timer_clr;
    logic               timer_inc;
    logic               timer_tc;
    logic [TMR_W-1:0]   timer_limit;
    logic [TMR_W-1:0]   timer_count;

    always_comb begin
        ref_code      = (state == LOCKOUT) ? master_code : user_code;
        ref_digit     = DIGIT_W'(code_digit(MAX_CODE_W'(ref_code), 32'(digit_pos), N_DIGITS, DIGIT_W));
        mismatch_next = mismatch | (digit_in != ref_digit);
        last_digit    = (digit_pos == POS_W'(N_DIGITS - 1));
        fail_inc      = (fail_count == CNT_W'(MAX_FAIL)) ? fail_count : fail_count + 1'b1;
        entry_active  = (state == ENTRY) || ((state == LOCKOUT) && (digit_pos != '0));
        timer_limit   = (state == OPEN) ? TMR_W'(OPEN_CYCLES - 1) : TMR_W'(TIMEOUT_CYCLES - 1);
        timer_inc     = entry_active || (state == OPEN);
        // Timer restarts on every accepted digit and on every state change.
        timer_clr     = fire_alarm || !timer_inc || timer_tc ||
                        ((state == OPEN) ? relock : digit_valid);
    end

    lock_timer #(.TMR_W(TMR_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (timer_clr),
        .inc   (timer_inc),
        .limit (timer_limit),
        .count (timer_count),
        .tc    (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            unlock     <= 1'b0;
            alarm      <= 1'b0;
            fail_count <= '0;
            digit_pos  <= '0;
            mismatch   <= 1'b0;
        end else if (fire_alarm) begin
            state     <= FIRE;
            unlock    <= 1'b1;
            digit_pos <= '0;
            mismatch  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, ENTRY, LOCKOUT: begin
                    if (digit_valid) begin
                        if (last_digit) begin
                            digit_pos <= '0;
                            mismatch  <= 1'b0;
                            if (state == LOCKOUT) begin
                                if (!mismatch_next) begin
                                    state      <= IDLE;
                                    alarm      <= 1'b0;
                                    fail_count <= '0;
                                end
                            end else if (!mismatch_next) begin
                                state      <= OPEN;
                                unlock     <= 1'b1;
                                fail_count <= '0;
                            end else begin
                                fail_count <= fail_inc;
                                if (fail_inc == CNT_W'(MAX_FAIL)) begin
                                    state <= LOCKOUT;
                                    alarm <= 1'b1;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end else begin
                            digit_pos <= digit_pos + 1'b1;
                            mismatch  <= mismatch_next;
                            if (state == IDLE) state <= ENTRY;
                        end
                    end else if (entry_active && timer_tc) begin
                        digit_pos <= '0;
                        mismatch  <= 1'b0;
                        if (state == ENTRY) state <= IDLE;
                    end
                end
                OPEN: begin
                    if (relock || timer_tc) begin
                        state  <= IDLE;
                        unlock <= 1'b0;
                    end
                end
                FIRE: begin
                    unlock <= 1'b0;
                    state  <= alarm ? LOCKOUT : IDLE;
                end
                default: begin
                    state  <= IDLE;
                    unlock <= 1'b0;
                end
            endcase
        end
    end

endmodule
